// File: rtl/usb_bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after every STUFF_LEN consecutive 1s.
// Optional macro BS_TAIL_STUFF_EN: also stuff after a run completed by the packet's last bit.
module usb_bit_stuffer #(
    parameter int STUFF_LEN = 6,
    parameter int CNT_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             bs_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    output logic [CNT_W-1:0] stuff_count
);

    localparam int                ONES_W  = $clog2(STUFF_LEN + 1);
    localparam logic [ONES_W-1:0] RUN_END = ONES_W'(STUFF_LEN - 1);
    localparam logic [ONES_W-1:0] ONE     = ONES_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XMIT  = 2'd1,
        STUFF = 2'd2
    } state_t;

    state_t            state_reg;
    logic [ONES_W-1:0] ones_cnt_reg;
    logic              tail_reg;
    logic              out_bit_reg;
    logic              out_valid_reg;
    logic              out_last_reg;
    logic [CNT_W-1:0]  stuff_count_reg;

    logic accept;
    logic run_done;
    logic stuff_now;

    assign bs_ready = (state_reg != STUFF);
    assign accept   = in_valid && bs_ready;
    assign run_done = in_bit && (ones_cnt_reg == RUN_END);

    // Whether the packet's final bit may still trigger an inserted 0.
`ifdef BS_TAIL_STUFF_EN
    assign stuff_now = run_done;
`else
    assign stuff_now = run_done && !in_last;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            ones_cnt_reg    <= '0;
            tail_reg        <= 1'b0;
            out_bit_reg     <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
            stuff_count_reg <= '0;
        end else begin
            out_bit_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            case (state_reg)
                IDLE, XMIT: begin
                    if (accept) begin
                        out_bit_reg   <= in_bit;
                        out_valid_reg <= 1'b1;
                        if (state_reg == IDLE) begin
                            stuff_count_reg <= '0;
                        end
                        if (stuff_now) begin
                            // out_last moves onto the inserted 0 when the tail bit stuffs
                            state_reg    <= STUFF;
                            tail_reg     <= in_last;
                            ones_cnt_reg <= ones_cnt_reg + ONE;
                        end else if (in_last) begin
                            out_last_reg <= 1'b1;
                            state_reg    <= IDLE;
                            ones_cnt_reg <= '0;
                        end else begin
                            state_reg    <= XMIT;
                            ones_cnt_reg <= in_bit ? (ones_cnt_reg + ONE) : '0;
                        end
                    end
                end
                STUFF: begin
                    out_bit_reg   <= 1'b0;
                    out_valid_reg <= 1'b1;
                    out_last_reg  <= tail_reg;
                    ones_cnt_reg  <= '0;
                    tail_reg      <= 1'b0;
                    state_reg     <= tail_reg ? IDLE : XMIT;
                    if (stuff_count_reg != CNT_MAX) begin
                        stuff_count_reg <= stuff_count_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    ones_cnt_reg <= '0;
                    tail_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign out_bit     = out_bit_reg;
    assign out_valid   = out_valid_reg;
    assign out_last    = out_last_reg;
    assign stuff_count = stuff_count_reg;

endmodule
